// File: rtl/rf_sched_pkg.sv
// Shared types for the register-file write scheduler.
// Holds the FSM state encoding and requester index constants.
package rf_sched_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Bundle between the writeback requesters / control unit and the scheduler.
// master: requesters + clear source + RF observer; slave: the scheduler.
interface rf_write_scheduler_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 16
);
   localparam int ADDR_W = $clog2(NUM_REGS);

   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;
   logic              rf_write;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;
   logic [CNT_W-1:0]  collisions;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output clr_req,
      input  req0_ready, req1_ready,
      input  clr_busy, clr_done,
      input  rf_write, rf_addr, rf_wdata,
      input  collisions
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  clr_req,
      output req0_ready, req1_ready,
      output clr_busy, clr_done,
      output rf_write, rf_addr, rf_wdata,
      output collisions
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
// Ports: clk, rst, en (grant allowed), valid[1:0] in; gnt[1:0] out (comb).
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] gnt
);
   import rf_sched_pkg::*;

   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (valid[REQ_ALU] && valid[REQ_MEM])
            gnt = last_grant ? 2'b01 : 2'b10;
         else
            gnt = valid;
      end
   end

   // Priority only rotates when a grant is actually taken.
   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b1;
      else if (|(gnt & valid))
         last_grant <= gnt[REQ_MEM];
   end

endmodule

// File: rtl/rf_write_scheduler.sv
// Owns the RF write port: arbitrates ALU/load writebacks and runs bulk clear.
// Ports: clk, rst (sync, active-high), bus (slave side of the scheduler if).
module rf_write_scheduler #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ZERO_R0  = 1,
   parameter int CNT_W    = 16
) (
   input logic               clk,
   input logic               rst,
   rf_write_scheduler_if.slave bus
);
   import rf_sched_pkg::*;

   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              busy_q;
   logic              done_q;
   logic [CNT_W-1:0]  coll_q;

   logic [1:0]        gnt;
   logic              en;
   logic              both;
   logic              acc;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;

   assign en   = (state == ARB) && !bus.clr_req;
   assign both = bus.req0_valid && bus.req1_valid;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .valid ({bus.req1_valid, bus.req0_valid}),
      .gnt   (gnt)
   );

   assign bus.req0_ready = gnt[REQ_ALU];
   assign bus.req1_ready = gnt[REQ_MEM];

   assign acc = (gnt[REQ_ALU] && bus.req0_valid) ||
                (gnt[REQ_MEM] && bus.req1_valid);
   assign acc_addr = gnt[REQ_ALU] ? bus.req0_addr : bus.req1_addr;
   assign acc_data = gnt[REQ_ALU] ? bus.req0_data : bus.req1_data;

   // Clear write for address 0 is issued on the entry edge so the sweep
   // shows on the port the cycle right after clr_req.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ARB;
         cnt    <= '0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         coll_q <= '0;
      end else begin
         unique case (state)
            ARB: begin
               if (bus.clr_req) begin
                  state  <= CLEAR;
                  cnt    <= '0;
                  wr_q   <= 1'b1;
                  addr_q <= '0;
                  data_q <= '0;
                  busy_q <= 1'b1;
               end else begin
                  if (acc) begin
                     addr_q <= acc_addr;
                     data_q <= acc_data;
                     wr_q   <= !((ZERO_R0 != 0) && (acc_addr == '0));
                  end else begin
                     wr_q <= 1'b0;
                  end
                  if (both && !(&coll_q))
                     coll_q <= coll_q + CNT_W'(1);
               end
            end
            CLEAR: begin
               if (cnt == LAST) begin
                  state  <= DONE;
                  wr_q   <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  cnt    <= cnt + ADDR_W'(1);
                  wr_q   <= 1'b1;
                  addr_q <= cnt + ADDR_W'(1);
                  data_q <= '0;
               end
            end
            DONE: begin
               state  <= ARB;
               wr_q   <= 1'b0;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: state <= ARB;
         endcase
      end
   end

   assign bus.rf_write   = wr_q;
   assign bus.rf_addr    = addr_q;
   assign bus.rf_wdata   = data_q;
   assign bus.clr_busy   = busy_q;
   assign bus.clr_done   = done_q;
   assign bus.collisions = coll_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed self-checking bench for rf_write_scheduler.
// One task per scenario, inline comparisons, single summary line.
module tb_rf_write_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   rf_write_scheduler_if #(.DATA_W(32), .NUM_REGS(32), .CNT_W(16)) bus ();

   rf_write_scheduler #(
      .DATA_W(32), .NUM_REGS(32), .ZERO_R0(1), .CNT_W(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 1'b0;
      bus.req0_addr  = '0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_addr  = '0;
      bus.req1_data  = '0;
      bus.clr_req    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.rf_write !== 1'b0 || bus.rf_addr !== 5'd0 ||
          bus.rf_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_rf: wr=%b addr=%0d data=%h want 0/0/0",
                  bus.rf_write, bus.rf_addr, bus.rf_wdata);
      end
      checks++;
      if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0 ||
          bus.collisions !== 16'd0) begin
         errors++;
         $display("FAIL reset_ctl: busy=%b done=%b coll=%0d want 0/0/0",
                  bus.clr_busy, bus.clr_done, bus.collisions);
      end
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: r0=%b r1=%b want 0/0",
                  bus.req0_ready, bus.req1_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'd5;
      bus.req0_data  = 32'd255;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_ready: r0=%b r1=%b want 1/0",
                  bus.req0_ready, bus.req1_ready);
      end
      tick();
      bus.req0_valid = 1'b0;
      checks++;
      if (bus.rf_write !== 1'b1 || bus.rf_addr !== 5'd5 ||
          bus.rf_wdata !== 32'd255) begin
         errors++;
         $display("FAIL single_write: wr=%b addr=%0d data=%0d want 1/5/255",
                  bus.rf_write, bus.rf_addr, bus.rf_wdata);
      end
      tick();
      checks++;
      if (bus.rf_write !== 1'b0 || bus.rf_addr !== 5'd5 ||
          bus.rf_wdata !== 32'd255) begin
         errors++;
         $display("FAIL single_after: wr=%b addr=%0d data=%0d want 0/5/255",
                  bus.rf_write, bus.rf_addr, bus.rf_wdata);
      end
   endtask

   task automatic test_tie();
      do_reset();
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'd3;
      bus.req0_data  = 32'hAA;
      bus.req1_valid = 1'b1;
      bus.req1_addr  = 5'd4;
      bus.req1_data  = 32'hBB;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL tie_first: r0=%b r1=%b want 1/0",
                  bus.req0_ready, bus.req1_ready);
      end
      tick();
      bus.req0_valid = 1'b0;
      #1;
      checks++;
      if (bus.rf_write !== 1'b1 || bus.rf_addr !== 5'd3 ||
          bus.rf_wdata !== 32'hAA || bus.req1_ready !== 1'b1) begin
         errors++;
         $display("FAIL tie_w0: wr=%b addr=%0d data=%h r1=%b want 1/3/aa/1",
                  bus.rf_write, bus.rf_addr, bus.rf_wdata, bus.req1_ready);
      end
      tick();
      bus.req1_valid = 1'b0;
      checks++;
      if (bus.rf_write !== 1'b1 || bus.rf_addr !== 5'd4 ||
          bus.rf_wdata !== 32'hBB) begin
         errors++;
         $display("FAIL tie_w1: wr=%b addr=%0d data=%h want 1/4/bb",
                  bus.rf_write, bus.rf_addr, bus.rf_wdata);
      end
      checks++;
      if (bus.collisions !== 16'd1) begin
         errors++;
         $display("FAIL tie_coll: got %0d want 1", bus.collisions);
      end
   endtask

   task automatic test_alternate();
      logic [4:0]  ea;
      logic [31:0] ed;
      int          g;
      do_reset();
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'd1;
      bus.req0_data  = 32'h100;
      bus.req1_valid = 1'b1;
      bus.req1_addr  = 5'd2;
      bus.req1_data  = 32'h200;
      for (int i = 0; i < 4; i++) begin
         g = i % 2;
         #1;
         checks++;
         if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
            errors++;
            $display("FAIL alt_grant%0d: r0=%b r1=%b want grant %0d",
                     i, bus.req0_ready, bus.req1_ready, g);
         end
         ea = (g == 0) ? 5'd1 : 5'd2;
         ed = (g == 0) ? bus.req0_data : bus.req1_data;
         tick();
         checks++;
         if (bus.rf_write !== 1'b1 || bus.rf_addr !== ea ||
             bus.rf_wdata !== ed) begin
            errors++;
            $display("FAIL alt_write%0d: wr=%b addr=%0d data=%h want 1/%0d/%h",
                     i, bus.rf_write, bus.rf_addr, bus.rf_wdata, ea, ed);
         end
         if (g == 0) bus.req0_data = bus.req0_data + 32'd1;
         else        bus.req1_data = bus.req1_data + 32'd1;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      checks++;
      if (bus.collisions !== 16'd4) begin
         errors++;
         $display("FAIL alt_coll: got %0d want 4", bus.collisions);
      end
      tick();
   endtask

   task automatic test_zero_r0();
      do_reset();
      bus.req1_valid = 1'b1;
      bus.req1_addr  = 5'd0;
      bus.req1_data  = 32'd7;
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1) begin
         errors++;
         $display("FAIL zr0_ready: got %b want 1", bus.req1_ready);
      end
      tick();
      bus.req1_valid = 1'b0;
      checks++;
      if (bus.rf_write !== 1'b0 || bus.rf_addr !== 5'd0 ||
          bus.rf_wdata !== 32'd7) begin
         errors++;
         $display("FAIL zr0_write: wr=%b addr=%0d data=%0d want 0/0/7",
                  bus.rf_write, bus.rf_addr, bus.rf_wdata);
      end
   endtask

   task automatic test_clear();
      do_reset();
      bus.clr_req    = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'd9;
      bus.req0_data  = 32'h55;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_T_ready: got %b want 0", bus.req0_ready);
      end
      tick();
      bus.clr_req = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         #1;
         checks++;
         if (bus.rf_write !== 1'b1 || bus.rf_addr !== 5'(k - 1) ||
             bus.rf_wdata !== 32'd0 || bus.clr_busy !== 1'b1 ||
             bus.clr_done !== 1'b0 || bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_sweep%0d: wr=%b a=%0d d=%h busy=%b done=%b r0=%b want 1/%0d/0/1/0/0",
                     k, bus.rf_write, bus.rf_addr, bus.rf_wdata,
                     bus.clr_busy, bus.clr_done, bus.req0_ready, k - 1);
         end
         tick();
      end
      #1;
      checks++;
      if (bus.clr_done !== 1'b1 || bus.rf_write !== 1'b0 ||
          bus.clr_busy !== 1'b1 || bus.req0_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_done: done=%b wr=%b busy=%b r0=%b want 1/0/1/0",
                  bus.clr_done, bus.rf_write, bus.clr_busy, bus.req0_ready);
      end
      tick();
      #1;
      checks++;
      if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0 ||
          bus.req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL clr_after: done=%b busy=%b r0=%b want 0/0/1",
                  bus.clr_done, bus.clr_busy, bus.req0_ready);
      end
      tick();
      bus.req0_valid = 1'b0;
      checks++;
      if (bus.rf_write !== 1'b1 || bus.rf_addr !== 5'd9 ||
          bus.rf_wdata !== 32'h55) begin
         errors++;
         $display("FAIL clr_held_req: wr=%b addr=%0d data=%h want 1/9/55",
                  bus.rf_write, bus.rf_addr, bus.rf_wdata);
      end
   endtask

   task automatic test_clear_rst();
      int done_seen;
      do_reset();
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         checks++;
         if (bus.rf_write !== 1'b1 || bus.rf_addr !== 5'(k - 1)) begin
            errors++;
            $display("FAIL clrrst_sweep%0d: wr=%b addr=%0d want 1/%0d",
                     k, bus.rf_write, bus.rf_addr, k - 1);
         end
         bus.clr_req = (k == 5);
         if (k < 11) tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req0_valid = 1'b1;
      #1;
      checks++;
      if (bus.rf_write !== 1'b0 || bus.clr_busy !== 1'b0 ||
          bus.clr_done !== 1'b0 || bus.req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL clrrst_abort: wr=%b busy=%b done=%b r0=%b want 0/0/0/1",
                  bus.rf_write, bus.clr_busy, bus.clr_done, bus.req0_ready);
      end
      bus.req0_valid = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.clr_done === 1'b1 || bus.clr_busy === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen !== 0) begin
         errors++;
         $display("FAIL clrrst_no_done: busy/done cycles=%0d want 0",
                  done_seen);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_tie();
      test_alternate();
      test_zero_r0();
      test_clear();
      test_clear_rst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
